// File: rtl/kovan_pkg.sv
// Shared constants and types for the back-EMF integrator and its saturating
// accumulator.
package kovan_pkg;

  localparam int NUM_MOTORS = 4;
  localparam int BEMF_W     = 32;
  localparam int ADC_W      = 10;
  localparam int DIFF_W     = ADC_W + 1;

  localparam logic [BEMF_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [BEMF_W-1:0] SAT_NEG = 32'h8000_0000;

  // S1 entry: raw p-n difference as an 11-bit two's complement value
  typedef struct packed {
    logic              valid;
    logic [1:0]        chan;
    logic [DIFF_W-1:0] data;
  } bemf_sample_t;

  // S2 entry: deadbanded, shifted and sign-extended contribution
  typedef struct packed {
    logic              valid;
    logic [1:0]        chan;
    logic [BEMF_W-1:0] data;
  } bemf_delta_t;

  function automatic logic [NUM_MOTORS-1:0] chan_dec(input logic [1:0] chan);
    logic [NUM_MOTORS-1:0] oh;
    oh       = '0;
    oh[chan] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bemf_integrator_sat_acc.sv
// 32-bit signed saturating accumulator with synchronous clear and a sticky
// saturation flag; clear takes priority over a same-cycle add.
module bemf_sat_acc
  import kovan_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [BEMF_W-1:0] d_i,
  output logic [BEMF_W-1:0] acc_o,
  output logic              sat_o,
  output logic              upd_o
);

  logic [BEMF_W-1:0] acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              upd_q, upd_d;
  logic [BEMF_W:0]   sum;

  // One guard bit: overflow shows up as the top two sum bits disagreeing.
  always_comb begin
    sum   = {acc_q[BEMF_W-1], acc_q} + {d_i[BEMF_W-1], d_i};
    acc_d = acc_q;
    sat_d = sat_q;
    upd_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (add_i) begin
      upd_d = |d_i;
      if (sum[BEMF_W] != sum[BEMF_W-1]) begin
        acc_d = sum[BEMF_W] ? SAT_NEG : SAT_POS;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[BEMF_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      upd_q <= upd_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/bemf_integrator.sv
// Back-EMF integrator: differential ADC samples -> per-motor signed position
// accumulators through a three-stage pipeline (diff, deadband/shift, accumulate).
module bemf_integrator
  import kovan_pkg::*;
#(
  parameter logic [ADC_W-1:0] DEADBAND = 10'd3,
  parameter logic [1:0]       SHIFT    = 2'd0
) (
  input  logic                  SYS_CLK,
  input  logic                  RESET,
  input  logic                  adc_valid,
  input  logic [1:0]            adc_chan,
  input  logic [ADC_W-1:0]      adc_data_p,
  input  logic [ADC_W-1:0]      adc_data_n,
  input  logic [NUM_MOTORS-1:0] mot_bemf_clear,
  output logic [BEMF_W-1:0]     bemf_0,
  output logic [BEMF_W-1:0]     bemf_1,
  output logic [BEMF_W-1:0]     bemf_2,
  output logic [BEMF_W-1:0]     bemf_3,
  output logic [NUM_MOTORS-1:0] bemf_sat,
  output logic [NUM_MOTORS-1:0] bemf_upd
);

  bemf_sample_t s1_d, s1_q;
  bemf_delta_t  s2_d, s2_q;

  logic signed [DIFF_W-1:0] diff_s1;
  logic signed [DIFF_W-1:0] shifted_s1;
  logic [DIFF_W-1:0]        mag_s1;
  logic [NUM_MOTORS-1:0]    add_vec;
  logic [BEMF_W-1:0]        acc [NUM_MOTORS];

  // A clear on the sample's channel drops it before it enters the pipe.
  always_comb begin
    s1_d.valid = adc_valid & ~mot_bemf_clear[adc_chan];
    s1_d.chan  = adc_chan;
    s1_d.data  = {1'b0, adc_data_p} - {1'b0, adc_data_n};
  end

  // Deadband is judged on the unshifted magnitude, so small diffs never leak
  // through even when the shift would round them toward a nonzero value.
  always_comb begin
    diff_s1    = s1_q.data;
    mag_s1     = diff_s1[DIFF_W-1] ? -diff_s1 : diff_s1;
    shifted_s1 = diff_s1 >>> SHIFT;
    s2_d.valid = s1_q.valid & ~mot_bemf_clear[s1_q.chan];
    s2_d.chan  = s1_q.chan;
    if (mag_s1 <= {1'b0, DEADBAND}) begin
      s2_d.data = '0;
    end else begin
      s2_d.data = {{(BEMF_W-DIFF_W){shifted_s1[DIFF_W-1]}}, shifted_s1};
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // S2 entries on a channel being cleared are killed inside the accumulator,
  // where clear already wins over the add.
  assign add_vec = s2_q.valid ? chan_dec(s2_q.chan) : '0;

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_acc
    bemf_sat_acc u_acc (
      .clk_i (SYS_CLK),
      .rst_i (RESET),
      .clr_i (mot_bemf_clear[i]),
      .add_i (add_vec[i]),
      .d_i   (s2_q.data),
      .acc_o (acc[i]),
      .sat_o (bemf_sat[i]),
      .upd_o (bemf_upd[i])
    );
  end

  assign bemf_0 = acc[0];
  assign bemf_1 = acc[1];
  assign bemf_2 = acc[2];
  assign bemf_3 = acc[3];

endmodule

// File: tb/tb_bemf_integrator.sv
// Bench for bemf_integrator: three parameterisations side by side plus the
// saturating accumulator on its own, checked against a cycle-history model.
module tb_bemf_integrator;
  import kovan_pkg::*;

  localparam int NDUT = 3;
  localparam int MAXC = 4096;
  localparam int DB [NDUT] = '{3, 3, 0};
  localparam int SH [NDUT] = '{0, 1, 2};
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  logic        SYS_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        adc_valid = 1'b0;
  logic [1:0]  adc_chan = '0;
  logic [9:0]  adc_data_p = '0;
  logic [9:0]  adc_data_n = '0;
  logic [3:0]  mot_bemf_clear = '0;
  logic [NDUT-1:0][3:0][31:0] b_acc;
  logic [NDUT-1:0][3:0]       b_sat;
  logic [NDUT-1:0][3:0]       b_upd;

  logic        sa_clr = 1'b0;
  logic        sa_add = 1'b0;
  logic [31:0] sa_d = '0;
  logic [31:0] sa_acc;
  logic        sa_sat;
  logic        sa_upd;

  always #5 SYS_CLK = ~SYS_CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bemf_integrator #(.DEADBAND(10'(DB[g])), .SHIFT(2'(SH[g]))) u_dut (
      .SYS_CLK        (SYS_CLK),
      .RESET          (RESET),
      .adc_valid      (adc_valid),
      .adc_chan       (adc_chan),
      .adc_data_p     (adc_data_p),
      .adc_data_n     (adc_data_n),
      .mot_bemf_clear (mot_bemf_clear),
      .bemf_0         (b_acc[g][0]),
      .bemf_1         (b_acc[g][1]),
      .bemf_2         (b_acc[g][2]),
      .bemf_3         (b_acc[g][3]),
      .bemf_sat       (b_sat[g]),
      .bemf_upd       (b_upd[g])
    );
  end

  bemf_sat_acc u_sat (
    .clk_i (SYS_CLK),
    .rst_i (RESET),
    .clr_i (sa_clr),
    .add_i (sa_add),
    .d_i   (sa_d),
    .acc_o (sa_acc),
    .sat_o (sa_sat),
    .upd_o (sa_upd)
  );

  // Input history, indexed by cycle number
  bit       hist_v   [MAXC];
  bit [1:0] hist_ch  [MAXC];
  int       hist_diff[MAXC];
  bit [3:0] hist_clr [MAXC];
  bit       hist_rst [MAXC];

  longint m_acc [NDUT][4];
  bit [3:0] m_sat [NDUT];
  bit [3:0] m_upd [NDUT];
  longint sa_m;
  bit     sa_sat_m, sa_upd_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pin(string nm, logic [31:0] act, logic [31:0] mdl, logic [31:0] lit);
    check({nm, " dut"}, act, lit);
    check({nm, " model"}, mdl, lit);
  endtask

  // Arithmetic right shift is floor division by 2^SHIFT.
  function automatic int model_d(int k, int diff);
    int mag = (diff < 0) ? -diff : diff;
    int den = 1 << SH[k];
    if (mag <= DB[k]) return 0;
    if (diff >= 0) return diff / den;
    return -((-diff + den - 1) / den);
  endfunction

  function automatic bit sat_add(longint a, longint d, output longint r);
    r = a + d;
    if (r > LMAX) begin r = LMAX; return 1'b1; end
    if (r < LMIN) begin r = LMIN; return 1'b1; end
    return 1'b0;
  endfunction

  // A sample from cycle n lands at the edge closing cycle n+2 unless a reset
  // or a clear on its channel occurs anywhere in cycles n..n+2.
  function automatic bit killed(int n, int t, bit [1:0] ch);
    for (int c = n; c <= t; c++)
      if (hist_rst[c] || hist_clr[c][ch]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(int t);
    longint r;
    bit hit;
    int d;
    bit [1:0] ch;
    for (int k = 0; k < NDUT; k++) m_upd[k] = '0;
    sa_upd_m = 1'b0;
    if (hist_rst[t]) begin
      for (int k = 0; k < NDUT; k++) begin
        m_sat[k] = '0;
        for (int i = 0; i < 4; i++) m_acc[k][i] = 0;
      end
      sa_m = 0;
      sa_sat_m = 1'b0;
      return;
    end
    if (t >= 2 && hist_v[t-2] && !killed(t-2, t, hist_ch[t-2])) begin
      ch = hist_ch[t-2];
      for (int k = 0; k < NDUT; k++) begin
        d = model_d(k, hist_diff[t-2]);
        if (d != 0) begin
          hit = sat_add(m_acc[k][ch], longint'(d), r);
          m_acc[k][ch] = r;
          if (hit) m_sat[k][ch] = 1'b1;
          m_upd[k][ch] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (hist_clr[t][i]) begin
        for (int k = 0; k < NDUT; k++) begin
          m_acc[k][i] = 0;
          m_sat[k][i] = 1'b0;
          m_upd[k][i] = 1'b0;
        end
      end
    end
    if (sa_clr) begin
      sa_m = 0;
      sa_sat_m = 1'b0;
    end else if (sa_add) begin
      hit = sat_add(sa_m, longint'($signed(sa_d)), r);
      sa_m = r;
      if (hit) sa_sat_m = 1'b1;
      sa_upd_m = (sa_d != 0);
    end
  endtask

  task automatic step();
    if (cyc >= MAXC) begin
      $display("FAIL cycle budget exceeded at cycle %0d", cyc);
      $fatal(1, "cycle budget");
    end
    hist_v[cyc]    = adc_valid;
    hist_ch[cyc]   = adc_chan;
    hist_diff[cyc] = int'(adc_data_p) - int'(adc_data_n);
    hist_clr[cyc]  = mot_bemf_clear;
    hist_rst[cyc]  = RESET;
    @(posedge SYS_CLK);
    model_edge(cyc);
    cyc++;
    #1;
  endtask

  task automatic drive(bit v, bit [1:0] ch, int p, int n, bit [3:0] clr, bit rst = 1'b0);
    adc_valid      = v;
    adc_chan       = ch;
    adc_data_p     = 10'(p);
    adc_data_n     = 10'(n);
    mot_bemf_clear = clr;
    RESET          = rst;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 0, 0, 4'h0);
  endtask

  task automatic sa_drive(bit clr, bit add, logic [31:0] d);
    sa_clr = clr;
    sa_add = add;
    sa_d   = d;
    idle(1);
  endtask

  always @(negedge SYS_CLK) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        for (int i = 0; i < 4; i++)
          check($sformatf("acc dut%0d m%0d cyc%0d", k, i, cyc), b_acc[k][i], m_acc[k][i][31:0]);
        check($sformatf("sat dut%0d cyc%0d", k, cyc), {28'd0, b_sat[k]}, {28'd0, m_sat[k]});
        check($sformatf("upd dut%0d cyc%0d", k, cyc), {28'd0, b_upd[k]}, {28'd0, m_upd[k]});
      end
      check($sformatf("sa_acc cyc%0d", cyc), sa_acc, sa_m[31:0]);
      check($sformatf("sa_sat cyc%0d", cyc), {31'd0, sa_sat}, {31'd0, sa_sat_m});
      check($sformatf("sa_upd cyc%0d", cyc), {31'd0, sa_upd}, {31'd0, sa_upd_m});
    end
  end

  initial begin
    int p, n;
    RESET = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    pin("reset accA0", b_acc[0][0], m_acc[0][0][31:0], 32'd0);
    pin("reset satA", {28'd0, b_sat[0]}, {28'd0, m_sat[0]}, 32'd0);

    // Basic accumulate
    drive(1'b1, 2'd1, 600, 500, 4'h0);
    idle(2);
    pin("t1 accA1", b_acc[0][1], m_acc[0][1][31:0], 32'd100);
    pin("t1 updA", {28'd0, b_upd[0]}, {28'd0, m_upd[0]}, 32'h2);
    pin("t1 accB1", b_acc[1][1], m_acc[1][1][31:0], 32'd50);
    pin("t1 accC1", b_acc[2][1], m_acc[2][1][31:0], 32'd25);
    pin("t1 accA0", b_acc[0][0], m_acc[0][0][31:0], 32'd0);

    // Deadband and sign
    drive(1'b0, 2'd0, 0, 0, 4'hF);
    drive(1'b1, 2'd0, 502, 500, 4'h0);
    drive(1'b1, 2'd0, 400, 450, 4'h0);
    idle(1);
    pin("t2 updA first", {28'd0, b_upd[0]}, {28'd0, m_upd[0]}, 32'h0);
    pin("t2 updC first", {28'd0, b_upd[2]}, {28'd0, m_upd[2]}, 32'h0);
    idle(1);
    pin("t2 accA0", b_acc[0][0], m_acc[0][0][31:0], -32'd50);
    pin("t2 updA", {28'd0, b_upd[0]}, {28'd0, m_upd[0]}, 32'h1);
    pin("t2 accB0", b_acc[1][0], m_acc[1][0][31:0], -32'd25);
    pin("t2 accC0", b_acc[2][0], m_acc[2][0][31:0], -32'd13);

    // Clear versus in-flight samples
    drive(1'b0, 2'd0, 0, 0, 4'hF);
    drive(1'b1, 2'd3, 700, 500, 4'h0);
    drive(1'b1, 2'd3, 700, 500, 4'h0);
    drive(1'b1, 2'd0, 550, 500, 4'h8);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      pin("t3 accA3", b_acc[0][3], m_acc[0][3][31:0], 32'd0);
    end
    pin("t3 accA0", b_acc[0][0], m_acc[0][0][31:0], 32'd50);

    // Back-to-back on one channel
    drive(1'b0, 2'd0, 0, 0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 510, 500, 4'h0);
      if (i == 2) pin("t4 accB0 first", b_acc[1][0], m_acc[1][0][31:0], 32'd5);
    end
    idle(2);
    pin("t4 accB0", b_acc[1][0], m_acc[1][0][31:0], 32'd40);
    pin("t4 accA0", b_acc[0][0], m_acc[0][0][31:0], 32'd80);
    pin("t4 accC0", b_acc[2][0], m_acc[2][0][31:0], 32'd16);

    // Reset mid-stream
    drive(1'b0, 2'd0, 0, 0, 4'hF);
    drive(1'b1, 2'd2, 600, 500, 4'h0);
    idle(2);
    pin("t5 pre accA2", b_acc[0][2], m_acc[0][2][31:0], 32'd100);
    drive(1'b1, 2'd2, 600, 500, 4'h0);
    drive(1'b1, 2'd2, 600, 500, 4'h0);
    drive(1'b1, 2'd2, 600, 500, 4'h0, 1'b1);
    pin("t5 rst accA2", b_acc[0][2], m_acc[0][2][31:0], 32'd0);
    drive(1'b1, 2'd2, 600, 500, 4'h0);
    pin("t5 c4 accA2", b_acc[0][2], m_acc[0][2][31:0], 32'd0);
    pin("t5 c4 updA", {28'd0, b_upd[0]}, {28'd0, m_upd[0]}, 32'h0);
    idle(1);
    pin("t5 c5 accA2", b_acc[0][2], m_acc[0][2][31:0], 32'd0);
    idle(2);
    pin("t5 late accA2", b_acc[0][2], m_acc[0][2][31:0], 32'd100);

    // Saturation on the accumulator itself
    sa_drive(1'b1, 1'b0, 32'h0);
    sa_drive(1'b0, 1'b1, 32'h7000_0000);
    pin("sat first", sa_acc, sa_m[31:0], 32'h7000_0000);
    sa_drive(1'b0, 1'b1, 32'h7000_0000);
    pin("sat pos acc", sa_acc, sa_m[31:0], 32'h7FFF_FFFF);
    pin("sat pos flag", {31'd0, sa_sat}, {31'd0, sa_sat_m}, 32'd1);
    sa_drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    pin("sat sticky acc", sa_acc, sa_m[31:0], 32'h7FFF_FFFE);
    pin("sat sticky flag", {31'd0, sa_sat}, {31'd0, sa_sat_m}, 32'd1);
    sa_drive(1'b1, 1'b1, 32'h10);
    pin("sat clr acc", sa_acc, sa_m[31:0], 32'h0);
    pin("sat clr flag", {31'd0, sa_sat}, {31'd0, sa_sat_m}, 32'd0);
    pin("sat clr upd", {31'd0, sa_upd}, {31'd0, sa_upd_m}, 32'd0);
    sa_drive(1'b0, 1'b1, 32'h8000_0000);
    pin("sat neg exact", sa_acc, sa_m[31:0], 32'h8000_0000);
    pin("sat neg exact flag", {31'd0, sa_sat}, {31'd0, sa_sat_m}, 32'd0);
    sa_drive(1'b0, 1'b1, 32'h8000_0000);
    pin("sat neg acc", sa_acc, sa_m[31:0], 32'h8000_0000);
    pin("sat neg flag", {31'd0, sa_sat}, {31'd0, sa_sat_m}, 32'd1);
    sa_drive(1'b0, 1'b0, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      p = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) begin
        n = p + $urandom_range(0, 8) - 4;
        if (n < 0) n = 0;
        if (n > 1023) n = 1023;
      end else begin
        n = $urandom_range(0, 1023);
      end
      sa_clr = ($urandom_range(0, 19) == 0);
      sa_add = $urandom_range(0, 1) == 1;
      sa_d   = $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), p, n,
            {$urandom_range(0, 23) == 0, $urandom_range(0, 23) == 0,
             $urandom_range(0, 23) == 0, $urandom_range(0, 23) == 0},
            $urandom_range(0, 299) == 0);
    end
    idle(3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
